// File: rtl/soric_efpga_pkg.sv
// Shared encodings for the eFPGA custom-function responder: operators,
// FSM states and the default datapath width.
package soric_efpga_pkg;

  localparam int unsigned EFPGA_WIDTH = 32;
  // Iterative operations (MUL, BITS) take one cycle per operand bit.
  localparam int unsigned ITER_CYCLES = EFPGA_WIDTH;

  localparam logic [1:0] OP_ALU  = 2'b00;
  localparam logic [1:0] OP_MUL  = 2'b01;
  localparam logic [1:0] OP_BITS = 2'b10;
  localparam logic [1:0] OP_ACC  = 2'b11;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StCalc  = 3'd1,
    StWait  = 3'd2,
    StDone  = 3'd3,
    StRearm = 3'd4
  } state_e;

endpackage

// File: rtl/soric_efpga_seq_mul.sv
// Iterative unsigned shift-add multiplier. The start edge loads the operands and
// folds in multiplier bit 0; the remaining WIDTH-1 bits take one cycle each.
module soric_efpga_seq_mul #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [2*WIDTH-1:0]   product_o
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  logic [CntW-1:0]      cnt_q;
  logic [2*WIDTH-1:0]   prod_q;
  logic [2*WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]     mplier_q;
  logic                 done_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        prod_q   <= b_i[0] ? {{WIDTH{1'b0}}, a_i} : '0;
        mcand_q  <= {{WIDTH{1'b0}}, a_i} << 1;
        mplier_q <= b_i >> 1;
        cnt_q    <= CntW'(WIDTH - 1);
        done_q   <= (WIDTH == 1);
      end else if (cnt_q != '0) begin
        if (mplier_q[0]) begin
          prod_q <= prod_q + mcand_q;
        end
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q - 1'b1;
        done_q   <= (cnt_q == CntW'(1));
      end
    end
  end

  assign busy_o    = (cnt_q != '0);
  assign done_o    = done_q;
  assign product_o = prod_q;

endmodule

// File: rtl/soric_efpga_responder.sv
// Stand-in for the eFPGA custom-function fabric: runs ALU/MUL/BITS/ACC operations
// behind the same en/done handshake the fabric uses.
module soric_efpga_responder
  import soric_efpga_pkg::*;
#(
  parameter int unsigned WIDTH = EFPGA_WIDTH
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             efpga_en_i,
  input  logic [1:0]       efpga_operator_i,
  input  logic [1:0]       efpga_delay_i,
  input  logic [WIDTH-1:0] efpga_operand_a_i,
  input  logic [WIDTH-1:0] efpga_operand_b_i,
  output logic [WIDTH-1:0] efpga_result_a_o,
  output logic [WIDTH-1:0] efpga_result_b_o,
  output logic [WIDTH-1:0] efpga_result_c_o,
  output logic             efpga_fpga_done_o,
  output logic             busy_o
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  state_e             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [1:0]         delay_q, delay_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               one_seen_q, one_seen_d;
  logic [WIDTH-1:0]   pend_a_q, pend_a_d, pend_b_q, pend_b_d, pend_c_q, pend_c_d;
  logic [WIDTH-1:0]   res_a_q, res_b_q, res_c_q;
  logic [WIDTH-1:0]   acc_q, acc_cnt_q, acc_next;
  logic               calc_end, commit, bit_out;

  logic               mul_start, mul_done, unused_mul_busy;
  logic [2*WIDTH-1:0] mul_product;

  assign mul_start = (state_q == StIdle) && efpga_en_i && (efpga_operator_i == OP_MUL);

  soric_efpga_seq_mul #(
    .WIDTH(WIDTH)
  ) u_seq_mul (
    .clk_i    (wb_clk_i),
    .rst_i    (wb_rst_i),
    .start_i  (mul_start),
    .a_i      (efpga_operand_a_i),
    .b_i      (efpga_operand_b_i),
    .busy_o   (unused_mul_busy),
    .done_o   (mul_done),
    .product_o(mul_product)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    delay_d    = delay_q;
    a_d        = a_q;
    b_d        = b_q;
    cnt_d      = cnt_q;
    one_seen_d = one_seen_q;
    pend_a_d   = pend_a_q;
    pend_b_d   = pend_b_q;
    pend_c_d   = pend_c_q;
    calc_end   = 1'b0;
    bit_out    = a_q[WIDTH-1];
    acc_next   = b_q[0] ? a_q : acc_q + a_q;

    unique case (state_q)
      StIdle: begin
        if (efpga_en_i) begin
          state_d    = StCalc;
          op_d       = efpga_operator_i;
          delay_d    = efpga_delay_i;
          a_d        = efpga_operand_a_i;
          b_d        = efpga_operand_b_i;
          cnt_d      = '0;
          one_seen_d = 1'b0;
          pend_a_d   = '0;
          pend_b_d   = '0;
          pend_c_d   = '0;
        end
      end
      StCalc: begin
        if (!efpga_en_i) begin
          state_d = StIdle;
        end else begin
          unique case (op_q)
            OP_ALU: begin
              pend_a_d = a_q + b_q;
              pend_b_d = a_q - b_q;
              pend_c_d = a_q ^ b_q;
              calc_end = 1'b1;
            end
            OP_MUL: begin
              pend_a_d = mul_product[WIDTH-1:0];
              pend_b_d = mul_product[2*WIDTH-1:WIDTH];
              pend_c_d = {{(WIDTH-1){1'b0}}, |mul_product[2*WIDTH-1:WIDTH]};
              calc_end = mul_done;
            end
            OP_BITS: begin
              // A streams out MSB-first; leading zeros count until the first one.
              a_d        = a_q << 1;
              pend_a_d   = pend_a_q + {{(WIDTH-1){1'b0}}, bit_out};
              pend_b_d   = pend_b_q + {{(WIDTH-1){1'b0}}, ~(one_seen_q | bit_out)};
              pend_c_d   = {bit_out, pend_c_q[WIDTH-1:1]};
              one_seen_d = one_seen_q | bit_out;
              cnt_d      = cnt_q + 1'b1;
              calc_end   = (cnt_q == CntW'(WIDTH - 1));
            end
            OP_ACC: begin
              pend_a_d = acc_next;
              pend_b_d = acc_q;
              pend_c_d = acc_cnt_q + 1'b1;
              calc_end = 1'b1;
            end
          endcase
          if (calc_end) begin
            state_d = (delay_q != 2'd0) ? StWait : StDone;
          end
        end
      end
      StWait: begin
        if (!efpga_en_i) begin
          state_d = StIdle;
        end else if (delay_q == 2'd1) begin
          state_d = StDone;
        end else begin
          delay_d = delay_q - 2'd1;
        end
      end
      StDone:  state_d = StRearm;
      StRearm: if (!efpga_en_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Results, acc and the ACC counter only move on the edge that enters DONE.
  assign commit = (state_d == StDone) && (state_q != StDone);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= StIdle;
      op_q       <= OP_ALU;
      delay_q    <= '0;
      a_q        <= '0;
      b_q        <= '0;
      cnt_q      <= '0;
      one_seen_q <= 1'b0;
      pend_a_q   <= '0;
      pend_b_q   <= '0;
      pend_c_q   <= '0;
      res_a_q    <= '0;
      res_b_q    <= '0;
      res_c_q    <= '0;
      acc_q      <= '0;
      acc_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      delay_q    <= delay_d;
      a_q        <= a_d;
      b_q        <= b_d;
      cnt_q      <= cnt_d;
      one_seen_q <= one_seen_d;
      pend_a_q   <= pend_a_d;
      pend_b_q   <= pend_b_d;
      pend_c_q   <= pend_c_d;
      if (commit) begin
        res_a_q <= pend_a_d;
        res_b_q <= pend_b_d;
        res_c_q <= pend_c_d;
        if (op_q == OP_ACC) begin
          acc_q     <= pend_a_d;
          acc_cnt_q <= pend_c_d;
        end
      end
    end
  end

  assign efpga_result_a_o  = res_a_q;
  assign efpga_result_b_o  = res_b_q;
  assign efpga_result_c_o  = res_c_q;
  assign efpga_fpga_done_o = (state_q == StDone);
  assign busy_o            = (state_q != StIdle);

endmodule
